// File: rtl/fb_pkg.sv
// Shared framebuffer constants, pixel/command types and the fill-colour helper.
package fb_pkg;
  localparam int FB_WIDTH  = 400;
  localparam int FB_HEIGHT = 240;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
    logic       pad;
  } rgb_pixel_t;

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} fb_state_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] w;
    logic [10:0] h;
    rgb_pixel_t  color;
  } fb_rect_t;

  // Checkerboard only needs the coordinate LSBs.
  function automatic rgb_pixel_t fb_pixel(input rgb_pixel_t color, input logic pattern,
                                          input logic x_lsb, input logic y_lsb);
    return (pattern && (x_lsb ^ y_lsb)) ? ~color : color;
  endfunction
endpackage

// File: rtl/fb_rect_clipper.sv
// Combinational clip of a rectangle command to the framebuffer; x1/y1 are exclusive bounds.
module fb_rect_clipper
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT
) (
  input  fb_rect_t    i_rect,
  output logic [10:0] o_x0,
  output logic [10:0] o_y0,
  output logic [11:0] o_x1,
  output logic [11:0] o_y1,
  output logic        o_empty
);
  logic [11:0] w_xe;
  logic [11:0] w_ye;
  logic        w_unused_color;

  // 12-bit sums cannot wrap for 11-bit operands.
  assign w_xe = {1'b0, i_rect.x} + {1'b0, i_rect.w};
  assign w_ye = {1'b0, i_rect.y} + {1'b0, i_rect.h};

  assign o_x0    = i_rect.x;
  assign o_y0    = i_rect.y;
  assign o_x1    = (w_xe > 12'(FB_WIDTH))  ? 12'(FB_WIDTH)  : w_xe;
  assign o_y1    = (w_ye > 12'(FB_HEIGHT)) ? 12'(FB_HEIGHT) : w_ye;
  assign o_empty = (i_rect.w == 11'd0) || (i_rect.h == 11'd0) ||
                   ({1'b0, i_rect.x} >= 12'(FB_WIDTH)) || ({1'b0, i_rect.y} >= 12'(FB_HEIGHT));

  assign w_unused_color = ^i_rect.color;
endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill engine: clips each command and emits one registered write per pixel, row-major.
// Checkerboard fill is available when FB_WRITER_CHECKER_EN is defined.
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
  parameter int ADDR_W    = 17,
  parameter int PIXEL_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [10:0]        cmd_x,
  input  logic [10:0]        cmd_y,
  input  logic [10:0]        cmd_w,
  input  logic [10:0]        cmd_h,
  input  logic [PIXEL_W-1:0] cmd_color,
`ifdef FB_WRITER_CHECKER_EN
  input  logic               cmd_pattern,
`endif
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [PIXEL_W-1:0] mem_data,
  input  logic               mem_ready,
  output logic               busy,
  output logic               done
);
  fb_state_t         r_state, w_next;
  fb_rect_t          r_rect;
  logic [10:0]       r_cur_x, r_cur_y;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [PIXEL_W-1:0] r_mem_data;

  logic [10:0]       w_x0, w_y0, w_nx, w_ny;
  logic [11:0]       w_x1, w_y1;
  logic              w_empty, w_pattern, w_eol, w_last, w_wr_acc, w_accept;
  logic [ADDR_W-1:0] w_nbase, w_base0;

  fb_rect_clipper #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT)) u_clip (
    .i_rect (r_rect),
    .o_x0   (w_x0),
    .o_y0   (w_y0),
    .o_x1   (w_x1),
    .o_y1   (w_y1),
    .o_empty(w_empty)
  );

`ifdef FB_WRITER_CHECKER_EN
  logic r_pattern;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_pattern <= 1'b0;
    else if (w_accept) r_pattern <= cmd_pattern;
  end
  assign w_pattern = r_pattern;
`else
  assign w_pattern = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && cmd_valid;
  assign w_wr_acc = r_mem_we && mem_ready;
  assign w_eol    = ({1'b0, r_cur_x} == (w_x1 - 12'd1));
  assign w_last   = w_eol && ({1'b0, r_cur_y} == (w_y1 - 12'd1));
  assign w_nx     = w_eol ? w_x0 : r_cur_x + 11'd1;
  assign w_ny     = w_eol ? r_cur_y + 11'd1 : r_cur_y;
  assign w_nbase  = w_eol ? r_row_base + ADDR_W'(FB_WIDTH) : r_row_base;
  // The only multiply; later rows step row_base by FB_WIDTH.
  assign w_base0  = ADDR_W'(w_y0) * ADDR_W'(FB_WIDTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = CLIP;
      end
      CLIP: begin
        busy   = 1'b1;
        w_next = w_empty ? DONE : FILL;
      end
      FILL: begin
        busy = 1'b1;
        if (w_wr_acc && w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rect     <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_row_base <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      if (w_accept) begin
        r_rect.x     <= cmd_x;
        r_rect.y     <= cmd_y;
        r_rect.w     <= cmd_w;
        r_rect.h     <= cmd_h;
        r_rect.color <= cmd_color;
      end
      if (r_state == CLIP && !w_empty) begin
        r_cur_x    <= w_x0;
        r_cur_y    <= w_y0;
        r_row_base <= w_base0;
        r_mem_we   <= 1'b1;
        r_mem_addr <= w_base0 + ADDR_W'(w_x0);
        r_mem_data <= fb_pixel(r_rect.color, w_pattern, w_x0[0], w_y0[0]);
      end
      if (r_state == FILL && w_wr_acc) begin
        if (w_last) begin
          r_mem_we <= 1'b0;
        end else begin
          r_cur_x    <= w_nx;
          r_cur_y    <= w_ny;
          r_row_base <= w_nbase;
          r_mem_addr <= w_nbase + ADDR_W'(w_nx);
          r_mem_data <= fb_pixel(r_rect.color, w_pattern, w_nx[0], w_ny[0]);
        end
      end
    end
  end

  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
endmodule
